// File: rtl/data_uncail_pkg.sv
// data_uncail_pkg: shared float32/int16 constants and burst FSM encoding
package data_uncail_pkg;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;
   localparam int LAT   = 3;
   localparam logic [15:0] INT16_MAX = 16'h7FFF;
   localparam logic [15:0] INT16_MIN = 16'h8000;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
endpackage

// File: rtl/f32_to_s16_pipe.sv
// f32_to_s16_pipe: three-stage float32 * 2^scale -> int16 with half-even rounding and saturation
module f32_to_s16_pipe
   import data_uncail_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   input  logic [7:0]  scale_exp,
   output logic        out_valid,
   output logic [15:0] out_data,
   output logic        sat_next,
   output logic        pending
);
   logic                 sgn, nan, zer, big, force_d, fsat_d;
   logic [EXP_W-1:0]     ex;
   logic [MAN_W-1:0]     man;
   logic signed [9:0]    e_d;
   logic [15:0]          fval_d;
   logic                 v1_q, s1_sgn_q, s1_force_q, s1_fsat_q;
   logic [MAN_W-1:0]     s1_man_q;
   logic signed [9:0]    s1_e_q;
   logic [15:0]          s1_fval_q;
   logic [9:0]           sh_w;
   logic [47:0]          x;
   logic                 v2_q, s2_sgn_q, s2_force_q, s2_fsat_q, s2_g_q, s2_st_q;
   logic [15:0]          s2_fval_q;
   logic [23:0]          s2_int_q, r;
   logic                 ovr, sat_d;
   logic [15:0]          res_d;
   // S1: unpack, classify, and fold constant-result classes into a forced value
   always_comb begin
      sgn    = in_data[31];
      ex     = in_data[MAN_W +: EXP_W];
      man    = in_data[MAN_W-1:0];
      e_d    = {2'b00, ex} - 10'(BIAS) + {{2{scale_exp[7]}}, scale_exp};
      nan    = &ex & |man;
      zer    = ~&ex & (~|ex | (e_d <= -10'sd2));
      big    = (&ex & ~|man) | (|ex & ~&ex & (e_d >= 10'sd15));
      force_d = nan | zer | big;
      fsat_d = nan | (big & ~(sgn & ~&ex & ~|man & (e_d == 10'sd15)));
      fval_d = (nan | zer) ? 16'h0000 : (sgn ? INT16_MIN : INT16_MAX);
   end
   // S1 registers
   always_ff @(posedge clk) begin
      v1_q       <= rst ? 1'b0 : in_valid;
      s1_sgn_q   <= sgn;
      s1_man_q   <= man;
      s1_e_q     <= e_d;
      s1_force_q <= force_d;
      s1_fsat_q  <= fsat_d;
      s1_fval_q  <= fval_d;
   end
   // S2: align mantissa so the integer part lands in x[47:24], guard at x[23], sticky below
   always_comb begin
      sh_w = 10'd23 - s1_e_q;
      x    = {1'b1, s1_man_q, 24'b0} >> sh_w;
   end
   // S2 registers
   always_ff @(posedge clk) begin
      v2_q       <= rst ? 1'b0 : v1_q;
      s2_sgn_q   <= s1_sgn_q;
      s2_force_q <= s1_force_q;
      s2_fsat_q  <= s1_fsat_q;
      s2_fval_q  <= s1_fval_q;
      s2_int_q   <= x[47:24];
      s2_g_q     <= x[23];
      s2_st_q    <= |x[22:0];
   end
   // S3: round half-to-even, clamp a rounded-up 32768 magnitude, apply sign
   always_comb begin
      r     = s2_int_q + {23'b0, s2_g_q & (s2_st_q | s2_int_q[0])};
      ovr   = |r[23:15];
      res_d = s2_force_q ? s2_fval_q : ovr ? (s2_sgn_q ? INT16_MIN : INT16_MAX) : (s2_sgn_q ? 16'h0000 - r[15:0] : r[15:0]);
      sat_d = s2_force_q ? s2_fsat_q : (ovr & ~s2_sgn_q);
   end
   // S3 output registers; data holds between valid samples
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= v2_q;
         if (v2_q) out_data <= res_d;
      end
   end
   assign sat_next = v2_q & sat_d;
   assign pending  = v1_q | v2_q;
endmodule

// File: rtl/data_uncail.sv
// data_uncail: burst-controlled float32 -> int16 uncalibration with saturation count
module data_uncail
   import data_uncail_pkg::*;
#(
   parameter int LEN_W  = 17,
   parameter int SATC_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  data_len,
   input  logic [7:0]        scale_exp,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              out_valid,
   output logic [15:0]       out_data,
   output logic              busy,
   output logic              done,
   output logic [SATC_W-1:0] sat_cnt
);
   state_e             state_q;
   logic [LEN_W-1:0]   len_q, cnt_q, cnt_d;
   logic [7:0]         scale_q;
   logic               busy_q, done_q, accept, sat_next, pending;
   logic [SATC_W-1:0]  sat_q;
   assign accept = (state_q == RUN) & in_valid;
   assign cnt_d  = cnt_q + LEN_W'(1);
   f32_to_s16_pipe u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_data   (in_data),
      .scale_exp (scale_q),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sat_next  (sat_next),
      .pending   (pending)
   );
   // burst FSM: count accepted samples, drain the pipe, pulse done, then return to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
         scale_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               len_q   <= data_len;
               scale_q <= scale_exp;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= (data_len == '0) ? DONE : RUN;
               done_q  <= (data_len == '0);
            end
            RUN: if (in_valid) begin
               cnt_q <= cnt_d;
               if (cnt_d == len_q) state_q <= FLUSH;
            end
            FLUSH: if (!pending) begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
   // saturation counter: cleared per burst, updates together with the saturated output, sticks at max
   always_ff @(posedge clk) begin
      if (rst || (state_q == IDLE && start)) sat_q <= '0;
      else if (sat_next && !(&sat_q)) sat_q <= sat_q + SATC_W'(1);
   end
   assign busy    = busy_q;
   assign done    = done_q;
   assign sat_cnt = sat_q;
endmodule

// File: tb/tb_data_uncail.sv
// tb_data_uncail: directed and random bursts checked against a timeline reference model
module tb_data_uncail;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic [16:0] data_len = '0;
   logic [7:0]  scale_exp = '0;
   logic [31:0] in_data = '0;
   logic        out_valid, busy, done;
   logic [15:0] out_data, sat_cnt;
   data_uncail dut (
      .clk(clk), .rst(rst), .start(start), .data_len(data_len), .scale_exp(scale_exp),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
      .busy(busy), .done(done), .sat_cnt(sat_cnt)
   );
   always #5 clk = ~clk;
   typedef struct {int c; int v; bit s;} exp_t;
   exp_t q[$];
   int nvec = 0, nerr = 0, cyc = 0, done_cyc = -10;
   int m_cnt = 0, m_len = 0, m_scale = 0, m_data = 0, m_sat = 0;
   bit m_busy = 0, m_run = 0;
   function automatic void conv(input logic [31:0] f, input int sc, output int v, output bit st);
      int e = int'(f[30:23]);
      int m = int'(f[22:0]);
      bit s = f[31];
      int ee = e - 127 + sc;
      longint mant, qt, rem, half;
      int k;
      st = 0;
      v = 0;
      if (e == 255) begin
         st = 1;
         v = (m != 0) ? 0 : (s ? -32768 : 32767);
      end else if (e == 0 || ee <= -2) begin
         v = 0;
      end else if (ee >= 15) begin
         v = s ? -32768 : 32767;
         st = !(s && ee == 15 && m == 0);
      end else begin
         mant = 64'h800000 + longint'(m);
         k = 23 - ee;
         qt = mant >> k;
         rem = mant - (qt << k);
         half = longint'(1) << (k - 1);
         if (rem > half || (rem == half && qt[0])) qt++;
         if (qt >= 32768) begin
            v = s ? -32768 : 32767;
            st = !s;
         end else v = s ? -int'(qt) : int'(qt);
      end
   endfunction
   task automatic chk(input string tag, input int obs, input int expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
      end
   endtask
   task automatic tick();
      int v;
      bit s;
      exp_t e;
      if (rst) begin
         q.delete();
         m_busy = 0; m_run = 0; m_sat = 0; m_data = 0; done_cyc = -10;
      end else if (start && !m_busy) begin
         m_busy = 1; m_len = int'(data_len); m_scale = int'($signed(scale_exp)); m_cnt = 0; m_sat = 0;
         m_run = (data_len != 0);
         if (data_len == 0) done_cyc = cyc + 1;
      end else if (m_run && in_valid) begin
         conv(in_data, m_scale, v, s);
         q.push_back('{cyc + 3, v, s});
         m_cnt++;
         if (m_cnt == m_len) begin
            m_run = 0;
            done_cyc = cyc + 4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == done_cyc + 1) m_busy = 0;
      if (q.size() > 0 && q[0].c == cyc) begin
         e = q.pop_front();
         m_data = e.v;
         if (e.s && m_sat < 65535) m_sat++;
         chk("out_valid", out_valid, 1);
      end else chk("out_valid", out_valid, 0);
      chk("out_data", $signed(out_data), m_data);
      chk("busy", busy, m_busy);
      chk("done", done, cyc == done_cyc);
      chk("sat_cnt", sat_cnt, m_sat);
   endtask
   task automatic go(input int len, input int sc);
      start = 1; data_len = 17'(len); scale_exp = 8'(sc); in_valid = 1; in_data = 32'h3F800000;
      tick();
      start = 0; in_valid = 0;
   endtask
   task automatic send(input logic [31:0] f);
      in_valid = 1; in_data = f;
      tick();
      in_valid = 0;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   function automatic logic [31:0] rf();
      int k = int'($urandom_range(0, 15));
      logic [31:0] r = $urandom;
      if (k == 0) return {r[31], 8'hFF, r[22:0]};
      if (k == 1) return {r[31], 8'h00, r[22:0]};
      if (k < 6) return {r[31], 8'($urandom_range(118, 145)), r[22:14], 14'b0};
      return {r[31], 8'($urandom_range(110, 150)), r[22:0]};
   endfunction
   initial begin
      logic [6:0] pat = 7'b1101101;
      int len, sent;
      idle(3);
      rst = 0;
      idle(2);
      go(4, 0);
      send(32'h3F800000); send(32'hBF800000); send(32'h40200000); send(32'h3F000000);
      idle(6);
      chk("b1_sat", sat_cnt, 0);
      go(4, 8);
      send(32'h42FE0000); send(32'h43000000); send(32'hC3000000); send(32'hC3000100);
      idle(6);
      chk("b2_sat", sat_cnt, 2);
      go(3, 0);
      send(32'h7FC00000); send(32'h7F800000); send(32'h00000001);
      idle(6);
      chk("b3_sat", sat_cnt, 2);
      go(6, 0);
      send(32'h3FC00000); send(32'hC0200000); send(32'hBF000000);
      send(32'h40600000); send(32'h46FFFF00); send(32'hC6FFFF00);
      idle(6);
      chk("ties_sat", sat_cnt, 1);
      start = 1; data_len = '0;
      tick();
      tick();
      start = 0;
      idle(3);
      chk("len0_idle", busy, 0);
      go(2, 0);
      go(5, 3);
      send(32'h40000000);
      idle(6);
      go(8, 0);
      for (int i = 0; i < 7; i++) begin
         if (pat[i]) send(rf());
         else tick();
      end
      rst = 1;
      tick();
      rst = 0;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      idle(5);
      for (int b = 0; b < 8; b++) begin
         len = int'($urandom_range(1, 24));
         go(len, int'($urandom_range(0, 24)) - 12);
         sent = 0;
         for (int k = 0; k < 200 && sent < len; k++) begin
            if ($urandom_range(0, 3) != 0) begin
               send(rf());
               sent++;
            end else tick();
         end
         send(rf());
         send(rf());
         idle(5);
         send(rf());
         idle(2);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
